// File: rtl/awgn_chan_pkg.sv
// Shared types and helpers for the BPSK channel stages: sample width, run/idle
// state encoding, integrator sizing and a saturating signed add.
package awgn_chan_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic                       ovf;
    logic signed [SAMPLE_W-1:0] sum;
  } sat_res_t;

  // Headroom of log2(spb) bits means a full bit of clamped samples never overflows.
  function automatic int acc_width(input int spb);
    return SAMPLE_W + $clog2(spb);
  endfunction

  function automatic sat_res_t sat_add(input logic signed [SAMPLE_W-1:0] a,
                                       input logic signed [SAMPLE_W-1:0] b);
    logic signed [SAMPLE_W:0] full;
    sat_res_t res;
    full    = (SAMPLE_W+1)'(a) + (SAMPLE_W+1)'(b);
    res.ovf = full[SAMPLE_W] ^ full[SAMPLE_W-1];
    if (!res.ovf)
      res.sum = full[SAMPLE_W-1:0];
    else if (full[SAMPLE_W])
      res.sum = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      res.sum = {1'b0, {(SAMPLE_W-1){1'b1}}};
    return res;
  endfunction

endpackage

// File: rtl/sat_add16.sv
// Combinational 16+16 -> 16 saturating signed adder with an overflow flag,
// shared by the channel and the interference stages.
module sat_add16
  import awgn_chan_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [SAMPLE_W-1:0] sum,
  output logic                       ovf
);

  sat_res_t res;

  assign res = sat_add(a, b);
  assign sum = res.sum;
  assign ovf = res.ovf;

endmodule

// File: rtl/awgn_bpsk_channel.sv
// BPSK channel plus integrate-and-dump receiver: adds noise to antipodal
// symbols with saturation, hard-decides every SPB samples and counts bit errors.
module awgn_bpsk_channel
  import awgn_chan_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] AMP   = 16'sd8192,
  parameter int                         SPB   = 16,
  parameter int                         CNT_W = 32
) (
  input  logic                       MCLK,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_stb,
  input  logic                       tx_bit,
  input  logic signed [SAMPLE_W-1:0] noise_in,
  input  logic                       clear_stats,
  output logic signed [SAMPLE_W-1:0] rx_sample,
  output logic                       rx_valid,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic [CNT_W-1:0]           bit_count,
  output logic [CNT_W-1:0]           err_count,
  output logic                       sat_seen
);

  localparam int ACC_W = acc_width(SPB);
  localparam int IDX_W = $clog2(SPB);

  state_t                     state;
  logic signed [ACC_W-1:0]    acc;
  logic [IDX_W-1:0]           idx;
  logic                       rx_tx_bit;
  logic                       ref_bit;
  logic signed [SAMPLE_W-1:0] sym;
  logic signed [SAMPLE_W-1:0] sum;
  logic                       ovf;
  logic signed [ACC_W-1:0]    total;
  logic                       run;
  logic                       last;
  logic                       decision;

  assign sym      = tx_bit ? AMP : -AMP;
  assign run      = (state == RUN) && enable;
  assign last     = (idx == IDX_W'(SPB - 1));
  assign total    = acc + ACC_W'(rx_sample);
  assign decision = ~total[ACC_W-1];

  sat_add16 u_add (
    .a   (sym),
    .b   (noise_in),
    .sum (sum),
    .ovf (ovf)
  );

  // Stage 1 registers the noisy sample; stage 2 integrates it one cycle later.
  // The transmitted bit rides along with the sample so the reference bit lines
  // up with the integrator index.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      rx_tx_bit <= 1'b0;
      ref_bit   <= 1'b0;
      rx_sample <= '0;
      rx_valid  <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
      sat_seen  <= 1'b0;
    end else begin
      state     <= enable ? RUN : IDLE;
      rx_valid  <= 1'b0;
      bit_valid <= 1'b0;
      if (!run) begin
        acc <= '0;
        idx <= '0;
      end else begin
        if (sample_stb) begin
          rx_sample <= sum;
          rx_valid  <= 1'b1;
          rx_tx_bit <= tx_bit;
          if (ovf)
            sat_seen <= 1'b1;
        end
        if (rx_valid) begin
          if (idx == '0)
            ref_bit <= rx_tx_bit;
          if (last) begin
            acc       <= '0;
            idx       <= '0;
            bit_out   <= decision;
            bit_valid <= 1'b1;
            if (bit_count != '1)
              bit_count <= bit_count + CNT_W'(1);
            if ((decision != ref_bit) && (err_count != '1))
              err_count <= err_count + CNT_W'(1);
          end else begin
            acc <= total;
            idx <= idx + IDX_W'(1);
          end
        end
      end
      // Placed last so a coincident decision is discarded rather than counted.
      if (clear_stats) begin
        bit_count <= '0;
        err_count <= '0;
        sat_seen  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/awgn_bpsk_channel.md
# awgn_bpsk_channel

Single-clock BPSK channel-and-receiver stage that sits directly downstream of the AWGN noise generator. It maps each transmitted data bit to an antipodal ±AMP sample and adds the generator's scaled Gaussian noise with 16-bit saturation. It then integrates and dumps over SPB samples per bit to make a hard decision, and keeps bit and bit-error counters for BER measurement in simulation and on the bench.

## Interface
- AMP, 16'sd8192: signed 16-bit symbol amplitude; bit 1 → +AMP, bit 0 → −AMP.
- SPB, 16: samples per bit; power of two, 2..256.
- CNT_W, 32: width of the bit and error counters.
- MCLK  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run enable; low flushes the integrator and holds counters.
- sample_stb  in  1  one-cycle strobe per channel sample (bpsk rate); may assert every cycle.
- tx_bit  in  1  transmitted data bit; sampled only with sample_stb.
- noise_in  in  16  signed noise sample (scaled mean/var generator output); sampled with sample_stb.
- clear_stats  in  1  synchronous clear of bit_count/err_count.
- rx_sample  out  16  signed saturated channel sample tx+noise.
- rx_valid  out  1  one-cycle pulse qualifying rx_sample.
- bit_out  out  1  hard decision.
- bit_valid  out  1  one-cycle pulse qualifying bit_out.
- bit_count  out  CNT_W  decided bits since clear.
- err_count  out  CNT_W  decisions differing from reference bit.
- sat_seen  out  1  sticky: any add saturated since reset/clear_stats.

## Operation
- States: IDLE (enable=0), RUN. IDLE→RUN when enable=1; RUN→IDLE when enable=0. Entering IDLE: acc, sample index, and in-flight rx_valid are cleared; counters and sat_seen hold.
- In RUN, on sample_stb: sym = tx_bit ? AMP : −AMP; sum = sym + noise_in in 17 bits; rx = clamp to [−32768, 32767]; sat_seen set if clamped.
- Integrator: acc is signed 16+log2(SPB) bits, cannot overflow. Sample index 0..SPB−1 wraps to 0 after SPB−1.
- At index 0, ref_bit is captured from tx_bit.
- On last sample (index SPB−1): total = acc + rx_sample; bit_out = (total ≥ 0), so exactly zero decides 1. bit_valid pulses, acc is reset to 0, bit_count increments, and err_count increments if bit_out ≠ ref_bit.
- Counters saturate at all-ones; no wrap.
- clear_stats zeroes bit_count, err_count, and sat_seen. If clear_stats coincides with a decision, clear wins and that decision is not counted.
- Strobes while enable=0 are ignored entirely.

## Timing
- Strobe at cycle N → rx_sample/rx_valid at N+1.
- Accumulate at N+2.
- Last-sample strobe at N → bit_out/bit_valid and updated counters visible at N+2.
- Back-to-back strobes are sustained at full rate with no stalls.
- Reset values: rx_sample 0, rx_valid 0, bit_out 0, bit_valid 0, bit_count 0, err_count 0, sat_seen 0, state IDLE, acc 0, index 0.
- Reset mid-bit discards the partial integration; no bit_valid is emitted for it.
- Deasserting enable between strobe N and N+2 kills the pending rx_valid/bit_valid; no decision is counted.

## Structure
- Package awgn_chan_pkg holds:
  - SAMPLE_W=16.
  - The state enum {IDLE, RUN}.
  - The acc-width function of SPB.
  - A saturating signed-add function.
- One sub-module, sat_add16: combinational 16+16 → 16 saturating adder with an overflow flag. It is reused by later interference stages.

## Test plan
- Noise 0, AMP 8192, SPB 16, tx_bit pattern 1,0,1,1 → bit_out 1,0,1,1; bit_count 4; err_count 0; rx_sample ±8192.
- tx_bit 1 with noise_in 30000 → rx_sample 32767, sat_seen 1. tx_bit 0 with noise −30000 → −32768.
- Constant noise −9000, all tx_bit 1, 8 bits → every bit_out 0; err_count 8.
- Total exactly 0 (tx 1, noise −8192 every sample) → bit_out 1; err 0.
- clear_stats on the same cycle as a decision with error → bit_count and err_count both 0 after.
- enable drop after 7 of 16 samples, then re-enable → no bit_valid for the partial bit; the next bit is decided after 16 fresh strobes. Synchronous reset mid-bit → all outputs return to reset values next cycle.
